aes256_ctr_decrypt_stream: RTL and testbench

- Streaming AES-256 CTR-mode decryptor. It is the receive-side counterpart of the multi-block CTR encryptor.
- Accepts up to MAX_BLOCKS 128-bit ciphertext blocks over a valid/ready handshake. For each block it requests a keystream block from the shared AES-256 encryption core by sending the current counter, XORs the keystream with the ciphertext, and emits plaintext over a valid/ready handshake.
- CTR decryption uses the forward cipher, so no inverse core is needed. The key is wired directly to the core and is not routed through this block.

---
 rtl/aes256_ctr_decrypt_stream.sv | 116 +++++++++++
 tb/tb_aes256_ctr_decrypt_stream.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes256_ctr_decrypt_stream.sv
// Streaming AES-256 CTR decryptor: requests one keystream block per ciphertext block from the
// shared forward AES core, XORs it in, and emits plaintext over a valid/ready handshake.
module aes256_ctr_decrypt_stream #(
  parameter int unsigned MAX_BLOCKS = 8,
  parameter int unsigned CTR_WIDTH  = 32,
  parameter int unsigned NB_W       = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [127:0]    iv,
  input  logic [NB_W-1:0] num_blocks,
  input  logic            ct_valid,
  output logic            ct_ready,
  input  logic [127:0]    ct_data,
  output logic            pt_valid,
  input  logic            pt_ready,
  output logic [127:0]    pt_data,
  output logic            pt_last,
  output logic            aes_req,
  output logic [127:0]    aes_ctr,
  input  logic            aes_ack,
  input  logic [127:0]    aes_ks,
  output logic            busy,
  output logic            done,
  output logic            err
);

  typedef enum logic [1:0] {StIdle, StReq, StXor, StOut} state_t;

  localparam logic [NB_W-1:0] MaxNb = NB_W'(MAX_BLOCKS);

  state_t          state_q, state_d;
  logic [127:0]    ctr_q, ks_q, pt_data_q, ctr_inc;
  logic [NB_W-1:0] nb_q, idx_q;
  logic            pt_last_q, done_q, err_q, start_ok;

  assign start_ok = (num_blocks != '0) && (num_blocks <= MaxNb);
  // Only the low CTR_WIDTH bits count; a wrap must not carry into the nonce part.
  assign ctr_inc  = {ctr_q[127:CTR_WIDTH], ctr_q[CTR_WIDTH-1:0] + CTR_WIDTH'(1)};

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start && start_ok) state_d = StReq;
      StReq:   if (aes_ack) state_d = StXor;
      StXor:   if (ct_valid) state_d = StOut;
      StOut:   if (pt_ready) state_d = pt_last_q ? StIdle : StReq;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctr_q     <= '0;
      ks_q      <= '0;
      pt_data_q <= '0;
      pt_last_q <= 1'b0;
      nb_q      <= '0;
      idx_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            if (start_ok) begin
              ctr_q <= iv;
              nb_q  <= num_blocks;
              idx_q <= '0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StReq: if (aes_ack) ks_q <= aes_ks;
        StXor: begin
          if (ct_valid) begin
            pt_data_q <= ct_data ^ ks_q;
            pt_last_q <= (idx_q == nb_q - NB_W'(1));
          end
        end
        StOut: begin
          if (pt_ready) begin
            if (pt_last_q) begin
              done_q <= 1'b1;
            end else begin
              idx_q <= idx_q + NB_W'(1);
              ctr_q <= ctr_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs decode the state register only.
  assign ct_ready = (state_q == StXor);
  assign pt_valid = (state_q == StOut);
  assign aes_req  = (state_q == StReq);
  assign busy     = (state_q != StIdle);
  assign aes_ctr  = ctr_q;
  assign pt_data  = pt_data_q;
  assign pt_last  = pt_last_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_aes256_ctr_decrypt_stream.sv
// Directed bench with a stub AES core and a scoreboard of expected counters and plaintexts.
module tb_aes256_ctr_decrypt_stream;

  localparam int NB_W = 4;
  localparam logic [127:0] NistIv = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  // AES-256 output block for NistIv under key 603deb10...0914dff4.
  localparam logic [127:0] NistKs = 128'h0bdf7df1591716335e9a8b15c860c502;
  localparam logic [127:0] NistCt = 128'h601ec313775789a5b7a7f504bbf3d228;

  typedef logic [127:0] blk_t [8];

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [127:0]    iv = '0;
  logic [NB_W-1:0] num_blocks = '0;
  logic            ct_valid = 1'b0;
  logic            ct_ready;
  logic [127:0]    ct_data = '0;
  logic            pt_valid;
  logic            pt_ready = 1'b1;
  logic [127:0]    pt_data;
  logic            pt_last;
  logic            aes_req;
  logic [127:0]    aes_ctr;
  logic            aes_ack;
  logic [127:0]    aes_ks;
  logic            busy, done, err;

  int n_vec = 0;
  int n_mis = 0;

  logic [127:0] exp_ctr_q [$];
  logic [128:0] exp_pt_q  [$];

  aes256_ctr_decrypt_stream #(.MAX_BLOCKS(8), .CTR_WIDTH(32), .NB_W(NB_W)) dut (
    .clk(clk), .rst(rst), .start(start), .iv(iv), .num_blocks(num_blocks),
    .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data), .pt_last(pt_last),
    .aes_req(aes_req), .aes_ctr(aes_ctr), .aes_ack(aes_ack), .aes_ks(aes_ks),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] ks_of(input logic [127:0] c);
    return (c == NistIv) ? NistKs : c;
  endfunction

  function automatic logic [127:0] inc(input logic [127:0] c);
    return {c[127:32], c[31:0] + 32'd1};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic expv);
    n_vec++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stub core: answers each request a fixed number of cycles later from the captured counter.
  logic         stub_ack = 1'b0, stub_pend = 1'b0, spur_ack = 1'b0;
  logic [1:0]   stub_cnt = '0;
  logic [127:0] stub_ks_q = '0, stub_cap = '0;
  assign aes_ack = stub_ack | spur_ack;
  assign aes_ks  = spur_ack ? '1 : stub_ks_q;

  always @(posedge clk) begin
    stub_ack <= 1'b0;
    if (stub_pend) begin
      if (stub_cnt == 2'd0) begin
        stub_ack  <= 1'b1;
        stub_ks_q <= ks_of(stub_cap);
        stub_pend <= 1'b0;
      end else begin
        stub_cnt <= stub_cnt - 2'd1;
      end
    end else if (aes_req && !stub_ack) begin
      stub_pend <= 1'b1;
      stub_cnt  <= 2'd1;
      stub_cap  <= aes_ctr;
    end
  end

  // Monitor: counters on each new request, plaintext on each handshake, done timing every cycle.
  bit done_due = 1'b0;
  bit req_seen = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      done_due = 1'b0;
      req_seen = 1'b0;
    end else begin
      chk1("done_pulse", done, done_due);
      done_due = pt_valid && pt_ready && pt_last;
      if (aes_req && !req_seen) begin
        chk1("ctr_expected", exp_ctr_q.size() != 0, 1'b1);
        if (exp_ctr_q.size() != 0) chk128("aes_ctr", aes_ctr, exp_ctr_q.pop_front());
      end
      req_seen = aes_req;
      if (pt_valid && pt_ready) begin
        chk1("pt_expected", exp_pt_q.size() != 0, 1'b1);
        if (exp_pt_q.size() != 0) begin
          logic [128:0] e;
          e = exp_pt_q.pop_front();
          chk128("pt_data", pt_data, e[127:0]);
          chk1("pt_last", pt_last, e[128]);
        end
      end
    end
  end

  task automatic run_msg(input logic [127:0] iv_v, input int nb, input blk_t cts,
                         input int ct_stall, input int pt_stall, input bit poke,
                         input int rst_blk);
    logic [127:0] c;
    c = iv_v;
    for (int i = 0; i < nb; i++) begin
      exp_ctr_q.push_back(c);
      exp_pt_q.push_back({(i == nb - 1), cts[i] ^ ks_of(c)});
      c = inc(c);
    end
    start = 1'b1; iv = iv_v; num_blocks = NB_W'(nb);
    tick();
    start = 1'b0; iv = rand128();
    chk1("req_latency", aes_req, 1'b1);
    chk1("busy_run", busy, 1'b1);
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < 50 && !ct_ready; k++) tick();
      chk1("ct_ready_wait", ct_ready, 1'b1);
      if (b == 0) begin
        for (int k = 0; k < ct_stall; k++) begin
          tick();
          chk1("ct_ready_hold", ct_ready, 1'b1);
        end
      end
      if (b == 0 && poke) begin
        start = 1'b1; num_blocks = NB_W'(1); spur_ack = 1'b1;
        tick();
        start = 1'b0; spur_ack = 1'b0;
        chk1("poke_ct_ready", ct_ready, 1'b1);
        chk1("poke_err", err, 1'b0);
      end
      ct_data = cts[b]; ct_valid = 1'b1;
      tick();
      ct_valid = 1'b0; ct_data = rand128();
      chk1("pt_valid_latency", pt_valid, 1'b1);
      chk1("ct_ready_out", ct_ready, 1'b0);
      if (b == rst_blk) begin
        pt_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk1("rst_ct_ready", ct_ready, 1'b0);
        chk1("rst_pt_valid", pt_valid, 1'b0);
        chk128("rst_pt_data", pt_data, '0);
        chk1("rst_pt_last", pt_last, 1'b0);
        chk1("rst_aes_req", aes_req, 1'b0);
        chk128("rst_aes_ctr", aes_ctr, '0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_err", err, 1'b0);
        rst = 1'b0; pt_ready = 1'b1;
        exp_ctr_q.delete();
        exp_pt_q.delete();
        repeat (8) tick();
        return;
      end
      if (b == 0 && pt_stall > 0) begin
        pt_ready = 1'b0;
        for (int k = 0; k < pt_stall; k++) begin
          tick();
          chk1("stall_pt_valid", pt_valid, 1'b1);
          chk128("stall_pt_data", pt_data, cts[0] ^ ks_of(iv_v));
          chk1("stall_ct_ready", ct_ready, 1'b0);
          chk1("stall_aes_req", aes_req, 1'b0);
        end
        pt_ready = 1'b1;
      end
      for (int k = 0; k < 50 && pt_valid; k++) tick();
      chk1("pt_drain", pt_valid, 1'b0);
    end
    chk1("idle_after_msg", busy, 1'b0);
    chk1("scoreboard_empty", (exp_pt_q.size() == 0) && (exp_ctr_q.size() == 0), 1'b1);
    tick();
  endtask

  initial begin
    blk_t cts;
    foreach (cts[i]) cts[i] = rand128();
    repeat (3) tick();
    chk1("reset_ct_ready", ct_ready, 1'b0);
    chk1("reset_pt_valid", pt_valid, 1'b0);
    chk128("reset_pt_data", pt_data, '0);
    chk1("reset_aes_req", aes_req, 1'b0);
    chk128("reset_aes_ctr", aes_ctr, '0);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_err", err, 1'b0);
    rst = 1'b0;
    tick();

    // Stub keystream = counter: ct 5,7 with counters 0,1 decrypts to 5,6.
    cts[0] = 128'h5; cts[1] = 128'h7;
    run_msg('0, 2, cts, 0, 0, 1'b0, -1);

    cts[0] = NistCt;
    run_msg(NistIv, 1, cts, 0, 0, 1'b0, -1);

    foreach (cts[i]) cts[i] = rand128();
    run_msg(128'h11111111_22222222_33333333_FFFFFFFF, 2, cts, 0, 0, 1'b0, -1);

    run_msg(rand128(), 3, cts, 4, 5, 1'b1, -1);

    foreach (cts[i]) cts[i] = rand128();
    run_msg(rand128(), 8, cts, 0, 0, 1'b0, -1);

    for (int t = 0; t < 2; t++) begin
      start = 1'b1; num_blocks = (t == 0) ? NB_W'(0) : NB_W'(9);
      tick();
      start = 1'b0;
      chk1("err_pulse", err, 1'b1);
      chk1("err_busy", busy, 1'b0);
      tick();
      chk1("err_clear", err, 1'b0);
      chk1("err_still_idle", busy, 1'b0);
    end

    run_msg(rand128(), 3, cts, 0, 0, 1'b0, 1);
    foreach (cts[i]) cts[i] = rand128();
    run_msg(128'h0123456789abcdef_00000000_fffffffe, 3, cts, 0, 0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
